// File: rtl/rob_commit_if.sv
// Issue / completion / commit bundle for the reorder buffer.
//   issue:      alloc_valid_IN, alloc_PC_IN -> alloc_ready_OUT, alloc_entry_OUT
//   completion: ROB_update_IN, ROB_entry_IN, RegWrite_IN, WriteRegister_IN, WriteData_IN
//   commit:     Commit_Valid_OUT, Commit_RegWrite_OUT, Commit_WriteRegister_OUT,
//               Commit_WriteData_OUT, Commit_PC_OUT, Count_OUT
//   control:    FLUSH_IN
interface rob_commit_if #(
  parameter int unsigned ENTRY_BITS = 6
);
  logic                  FLUSH_IN;
  logic                  alloc_valid_IN;
  logic [31:0]           alloc_PC_IN;
  logic                  alloc_ready_OUT;
  logic [ENTRY_BITS-1:0] alloc_entry_OUT;
  logic                  ROB_update_IN;
  logic [ENTRY_BITS-1:0] ROB_entry_IN;
  logic                  RegWrite_IN;
  logic [4:0]            WriteRegister_IN;
  logic [31:0]           WriteData_IN;
  logic                  Commit_Valid_OUT;
  logic                  Commit_RegWrite_OUT;
  logic [4:0]            Commit_WriteRegister_OUT;
  logic [31:0]           Commit_WriteData_OUT;
  logic [31:0]           Commit_PC_OUT;
  logic [ENTRY_BITS:0]   Count_OUT;

  // ROB side
  modport slave (
    input  FLUSH_IN, alloc_valid_IN, alloc_PC_IN,
    input  ROB_update_IN, ROB_entry_IN, RegWrite_IN, WriteRegister_IN, WriteData_IN,
    output alloc_ready_OUT, alloc_entry_OUT,
    output Commit_Valid_OUT, Commit_RegWrite_OUT, Commit_WriteRegister_OUT,
    output Commit_WriteData_OUT, Commit_PC_OUT, Count_OUT
  );

  // pipeline side (issue, MEM, register file)
  modport master (
    output FLUSH_IN, alloc_valid_IN, alloc_PC_IN,
    output ROB_update_IN, ROB_entry_IN, RegWrite_IN, WriteRegister_IN, WriteData_IN,
    input  alloc_ready_OUT, alloc_entry_OUT,
    input  Commit_Valid_OUT, Commit_RegWrite_OUT, Commit_WriteRegister_OUT,
    input  Commit_WriteData_OUT, Commit_PC_OUT, Count_OUT
  );
endinterface

// File: rtl/rob_commit.sv
// Reorder buffer with in-order single-wide commit.
//   CLK   : rising-edge clock
//   RESET : asynchronous active-low reset
//   bus   : rob_commit_if.slave (issue allocation, MEM completion, commit port)
module rob_commit #(
  parameter int unsigned ENTRY_BITS = 6
) (
  input  logic         CLK,
  input  logic         RESET,
  rob_commit_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << ENTRY_BITS;
  localparam int unsigned CW    = ENTRY_BITS + 1;

  logic [DEPTH-1:0]      valid_q, valid_d, done_q, done_d;
  logic [ENTRY_BITS-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  // per-entry payload; only read once the matching valid/done bits are set
  logic                  rw_q    [DEPTH];
  logic [4:0]            wreg_q  [DEPTH];
  logic [31:0]           wdata_q [DEPTH];
  logic [31:0]           pc_q    [DEPTH];

  logic                  cv_q, cv_d, crw_q, crw_d;
  logic [4:0]            creg_q, creg_d;
  logic [31:0]           cdata_q, cdata_d, cpc_q, cpc_d;

  logic full_c, alloc_fire_c, commit_fire_c, upd_hit_c;

  // handshake decisions, all taken on current state (no bypass)
  always_comb begin
    full_c        = (count_q == CW'(DEPTH));
    alloc_fire_c  = bus.alloc_valid_IN && !full_c;
    commit_fire_c = valid_q[head_q] && done_q[head_q];
    upd_hit_c     = bus.ROB_update_IN && valid_q[bus.ROB_entry_IN];
  end

  // next state: completion, then commit clear, then allocate; flush overrides all
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    cv_d    = 1'b0;
    crw_d   = 1'b0;
    creg_d  = creg_q;
    cdata_d = cdata_q;
    cpc_d   = cpc_q;
    if (bus.FLUSH_IN) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (upd_hit_c) begin
        done_d[bus.ROB_entry_IN] = 1'b1;
      end
      if (commit_fire_c) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = ENTRY_BITS'(head_q + 1'b1);
        cv_d            = 1'b1;
        crw_d           = rw_q[head_q];
        creg_d          = wreg_q[head_q];
        cdata_d         = wdata_q[head_q];
        cpc_d           = pc_q[head_q];
      end
      // the tail slot is never the committing head: equal pointers with count<64 means empty
      if (alloc_fire_c) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        tail_d          = ENTRY_BITS'(tail_q + 1'b1);
      end
      count_d = CW'(count_q + CW'(alloc_fire_c) - CW'(commit_fire_c));
    end
  end

  // control and commit-port registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      cv_q    <= 1'b0;
      crw_q   <= 1'b0;
      creg_q  <= '0;
      cdata_q <= '0;
      cpc_q   <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cv_q    <= cv_d;
      crw_q   <= crw_d;
      creg_q  <= creg_d;
      cdata_q <= cdata_d;
      cpc_q   <= cpc_d;
    end
  end

  // payload storage, no reset needed
  always_ff @(posedge CLK) begin
    if (!bus.FLUSH_IN && alloc_fire_c) begin
      pc_q[tail_q] <= bus.alloc_PC_IN;
    end
    if (!bus.FLUSH_IN && upd_hit_c) begin
      rw_q[bus.ROB_entry_IN]    <= bus.RegWrite_IN;
      wreg_q[bus.ROB_entry_IN]  <= bus.WriteRegister_IN;
      wdata_q[bus.ROB_entry_IN] <= bus.WriteData_IN;
    end
  end

  assign bus.alloc_ready_OUT          = !full_c;
  assign bus.alloc_entry_OUT          = tail_q;
  assign bus.Commit_Valid_OUT         = cv_q;
  assign bus.Commit_RegWrite_OUT      = crw_q;
  assign bus.Commit_WriteRegister_OUT = creg_q;
  assign bus.Commit_WriteData_OUT     = cdata_q;
  assign bus.Commit_PC_OUT            = cpc_q;
  assign bus.Count_OUT                = count_q;
endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: directed scenarios plus a randomized run
// compared against a program-order queue model of the reorder buffer.
module tb_rob_commit;
  logic CLK;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  rob_commit_if #(.ENTRY_BITS(6)) bus ();
  rob_commit #(.ENTRY_BITS(6)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] pc;
    bit          done;
    bit          rw;
    logic [4:0]  wreg;
    logic [31:0] wdata;
  } ent_t;

  // reference model: in-flight instructions in program order
  ent_t        m_q[$];
  int          m_tail;
  bit          e_cv, e_crw;
  logic [4:0]  e_creg;
  logic [31:0] e_cdata, e_cpc;

  task automatic m_reset();
    m_q.delete();
    m_tail = 0;
    e_cv = 0; e_crw = 0; e_creg = '0; e_cdata = '0; e_cpc = '0;
  endtask

  // advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    int   n;
    bit   cm;
    ent_t e;
    if (bus.FLUSH_IN) begin
      m_q.delete();
      m_tail = 0;
      e_cv = 0; e_crw = 0;
      return;
    end
    n  = m_q.size();
    cm = (n > 0) && m_q[0].done;
    if (cm) begin
      e = m_q[0];
      e_cv = 1; e_crw = e.rw; e_creg = e.wreg; e_cdata = e.wdata; e_cpc = e.pc;
    end else begin
      e_cv = 0; e_crw = 0;
    end
    if (bus.ROB_update_IN) begin
      foreach (m_q[i]) begin
        if (m_q[i].tag == bus.ROB_entry_IN) begin
          e = m_q[i];
          e.done = 1; e.rw = bus.RegWrite_IN; e.wreg = bus.WriteRegister_IN; e.wdata = bus.WriteData_IN;
          m_q[i] = e;
        end
      end
    end
    if (cm) void'(m_q.pop_front());
    if (bus.alloc_valid_IN && n < 64) begin
      e.tag = 6'(m_tail); e.pc = bus.alloc_PC_IN; e.done = 0;
      e.rw = 0; e.wreg = '0; e.wdata = '0;
      m_q.push_back(e);
      m_tail = (m_tail + 1) % 64;
    end
  endtask

  task automatic idle();
    bus.FLUSH_IN = 0; bus.alloc_valid_IN = 0; bus.alloc_PC_IN = '0;
    bus.ROB_update_IN = 0; bus.ROB_entry_IN = '0; bus.RegWrite_IN = 0;
    bus.WriteRegister_IN = '0; bus.WriteData_IN = '0;
  endtask

  task automatic cyc();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle();
    RESET = 0;
    m_reset();
    @(posedge CLK); @(posedge CLK);
    #1;
    RESET = 1;
  endtask

  task automatic alloc(input logic [31:0] pc);
    idle(); bus.alloc_valid_IN = 1; bus.alloc_PC_IN = pc; cyc();
  endtask

  task automatic complete(input logic [5:0] tag, input logic [4:0] r, input logic [31:0] d);
    idle(); bus.ROB_update_IN = 1; bus.ROB_entry_IN = tag; bus.RegWrite_IN = 1;
    bus.WriteRegister_IN = r; bus.WriteData_IN = d; cyc();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.Count_OUT !== 7'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.Count_OUT); end
    checks++; if (bus.alloc_ready_OUT !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.alloc_ready_OUT); end
    checks++; if (bus.alloc_entry_OUT !== 6'd0) begin errors++; $display("FAIL reset_entry got %0d want 0", bus.alloc_entry_OUT); end
    checks++; if ({bus.Commit_Valid_OUT, bus.Commit_RegWrite_OUT, bus.Commit_WriteRegister_OUT,
                   bus.Commit_WriteData_OUT, bus.Commit_PC_OUT} !== '0) begin
      errors++; $display("FAIL reset_commit got v=%b pc=%h want all zero", bus.Commit_Valid_OUT, bus.Commit_PC_OUT);
    end
  endtask

  task automatic test_ordering();
    logic [4:0]  wr [3] = '{5'd1, 5'd2, 5'd3};
    logic [31:0] wd [3] = '{32'hA, 32'hB, 32'hC};
    logic [31:0] wp [3] = '{32'h100, 32'h104, 32'h108};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.alloc_entry_OUT !== 6'(i)) begin errors++; $display("FAIL order_tag got %0d want %0d", bus.alloc_entry_OUT, i); end
      alloc(wp[i]);
    end
    complete(6'd2, 5'd3, 32'hC);
    complete(6'd0, 5'd1, 32'hA);
    checks++; if (bus.Commit_Valid_OUT !== 1'b0) begin errors++; $display("FAIL order_early got %b want 0", bus.Commit_Valid_OUT); end
    complete(6'd1, 5'd2, 32'hB);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.Commit_Valid_OUT !== 1'b1 || bus.Commit_RegWrite_OUT !== 1'b1 || bus.Commit_WriteRegister_OUT !== wr[i] ||
          bus.Commit_WriteData_OUT !== wd[i] || bus.Commit_PC_OUT !== wp[i]) begin
        errors++;
        $display("FAIL order_commit%0d got v=%b r%0d d=%h pc=%h want v=1 r%0d d=%h pc=%h", i, bus.Commit_Valid_OUT,
                 bus.Commit_WriteRegister_OUT, bus.Commit_WriteData_OUT, bus.Commit_PC_OUT, wr[i], wd[i], wp[i]);
      end
      idle(); cyc();
    end
    checks++; if (bus.Commit_Valid_OUT !== 1'b0 || bus.Count_OUT !== 7'd0) begin
      errors++; $display("FAIL order_drain got v=%b count=%0d want v=0 count=0", bus.Commit_Valid_OUT, bus.Count_OUT);
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 64; i++) alloc(32'h2000 + 32'(i * 4));
    checks++; if (bus.Count_OUT !== 7'd64 || bus.alloc_ready_OUT !== 1'b0) begin
      errors++; $display("FAIL full_state got count=%0d ready=%b want 64 0", bus.Count_OUT, bus.alloc_ready_OUT);
    end
    alloc(32'hDEAD0000);
    checks++; if (bus.Count_OUT !== 7'd64 || bus.alloc_entry_OUT !== 6'd0) begin
      errors++; $display("FAIL full_drop got count=%0d tail=%0d want 64 0", bus.Count_OUT, bus.alloc_entry_OUT);
    end
    complete(6'd0, 5'd7, 32'h77);
    idle(); cyc();
    checks++; if (bus.Commit_Valid_OUT !== 1'b1 || bus.Commit_PC_OUT !== 32'h2000) begin
      errors++; $display("FAIL full_commit got v=%b pc=%h want 1 2000", bus.Commit_Valid_OUT, bus.Commit_PC_OUT);
    end
    checks++; if (bus.Count_OUT !== 7'd63 || bus.alloc_ready_OUT !== 1'b1 || bus.alloc_entry_OUT !== 6'd0) begin
      errors++; $display("FAIL full_free got count=%0d ready=%b tag=%0d want 63 1 0", bus.Count_OUT, bus.alloc_ready_OUT, bus.alloc_entry_OUT);
    end
    alloc(32'h3000);
    checks++; if (bus.Count_OUT !== 7'd64 || bus.alloc_entry_OUT !== 6'd1) begin
      errors++; $display("FAIL full_realloc got count=%0d tail=%0d want 64 1", bus.Count_OUT, bus.alloc_entry_OUT);
    end
  endtask

  task automatic test_steady();
    do_reset();
    for (int i = 0; i < 60; i++) alloc(32'h1000 + 32'(i * 4));
    for (int i = 0; i < 12; i++) begin
      idle();
      bus.alloc_valid_IN = 1; bus.alloc_PC_IN = 32'h5000 + 32'(i);
      bus.ROB_update_IN = 1; bus.ROB_entry_IN = 6'(i); bus.RegWrite_IN = 1;
      bus.WriteRegister_IN = 5'(i); bus.WriteData_IN = 32'(i * 3);
      cyc();
      checks++; if (bus.alloc_entry_OUT !== 6'((61 + i) % 64)) begin
        errors++; $display("FAIL steady_tail got %0d want %0d", bus.alloc_entry_OUT, (61 + i) % 64);
      end
      if (i >= 1) begin
        checks++; if (bus.Count_OUT !== 7'd61 || bus.Commit_Valid_OUT !== 1'b1 || bus.Commit_PC_OUT !== 32'h1000 + 32'((i - 1) * 4)) begin
          errors++; $display("FAIL steady_cycle%0d got count=%0d v=%b pc=%h want 61 1 %h", i, bus.Count_OUT,
                             bus.Commit_Valid_OUT, bus.Commit_PC_OUT, 32'h1000 + 32'((i - 1) * 4));
        end
      end
    end
    idle();
  endtask

  task automatic test_stray();
    do_reset();
    complete(6'd5, 5'd9, 32'h55);
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.Count_OUT !== 7'd0 || bus.Commit_Valid_OUT !== 1'b0 || bus.alloc_entry_OUT !== 6'd0) begin
        errors++; $display("FAIL stray_ignored got count=%0d v=%b tail=%0d want 0 0 0", bus.Count_OUT, bus.Commit_Valid_OUT, bus.alloc_entry_OUT);
      end
      idle(); cyc();
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) alloc(32'h400 + 32'(i * 4));
    complete(6'd1, 5'd2, 32'h22);
    complete(6'd0, 5'd1, 32'h11);
    idle();
    bus.FLUSH_IN = 1; bus.alloc_valid_IN = 1; bus.alloc_PC_IN = 32'h999;
    bus.ROB_update_IN = 1; bus.ROB_entry_IN = 6'd2; bus.RegWrite_IN = 1; bus.WriteRegister_IN = 5'd3;
    cyc();
    checks++; if (bus.Commit_Valid_OUT !== 1'b0 || bus.Commit_RegWrite_OUT !== 1'b0 || bus.Count_OUT !== 7'd0 || bus.alloc_entry_OUT !== 6'd0) begin
      errors++; $display("FAIL flush_state got v=%b rw=%b count=%0d tail=%0d want 0 0 0 0", bus.Commit_Valid_OUT,
                         bus.Commit_RegWrite_OUT, bus.Count_OUT, bus.alloc_entry_OUT);
    end
    complete(6'd0, 5'd1, 32'h11);
    for (int i = 0; i < 2; i++) begin
      idle(); cyc();
      checks++; if (bus.Commit_Valid_OUT !== 1'b0 || bus.Count_OUT !== 7'd0) begin
        errors++; $display("FAIL flush_late_update got v=%b count=%0d want 0 0", bus.Commit_Valid_OUT, bus.Count_OUT);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    alloc(32'h700);
    complete(6'd0, 5'd4, 32'h44);
    idle(); cyc();
    checks++; if (bus.Commit_Valid_OUT !== 1'b1) begin errors++; $display("FAIL areset_setup got v=%b want 1", bus.Commit_Valid_OUT); end
    #2 RESET = 0;
    #1;
    checks++; if (bus.Commit_Valid_OUT !== 1'b0 || bus.Commit_RegWrite_OUT !== 1'b0 || bus.Commit_WriteRegister_OUT !== 5'd0 ||
                  bus.Commit_WriteData_OUT !== 32'd0 || bus.Commit_PC_OUT !== 32'd0 || bus.Count_OUT !== 7'd0 ||
                  bus.alloc_ready_OUT !== 1'b1 || bus.alloc_entry_OUT !== 6'd0) begin
      errors++; $display("FAIL areset_immediate got v=%b pc=%h count=%0d tail=%0d want all zero, ready 1", bus.Commit_Valid_OUT,
                         bus.Commit_PC_OUT, bus.Count_OUT, bus.alloc_entry_OUT);
    end
    m_reset();
    @(posedge CLK); #1;
    RESET = 1;
    idle(); cyc();
    checks++; if (bus.Commit_Valid_OUT !== 1'b0 || bus.Count_OUT !== 7'd0 || bus.alloc_entry_OUT !== 6'd0) begin
      errors++; $display("FAIL areset_release got v=%b count=%0d tail=%0d want 0 0 0", bus.Commit_Valid_OUT, bus.Count_OUT, bus.alloc_entry_OUT);
    end
  endtask

  task automatic test_random();
    int pa, pu;
    do_reset();
    for (int ph = 0; ph < 8; ph++) begin
      pa = (ph % 2 == 0) ? 85 : 35;
      pu = (ph % 2 == 0) ? 30 : 80;
      for (int c = 0; c < 300; c++) begin
        idle();
        bus.FLUSH_IN         = ($urandom_range(0, 199) == 0);
        bus.alloc_valid_IN   = ($urandom_range(0, 99) < pa);
        bus.alloc_PC_IN      = $urandom;
        bus.ROB_update_IN    = ($urandom_range(0, 99) < pu);
        if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
          bus.ROB_entry_IN = m_q[$urandom_range(0, m_q.size() - 1)].tag;
        else
          bus.ROB_entry_IN = 6'($urandom);
        bus.RegWrite_IN      = 1'($urandom);
        bus.WriteRegister_IN = 5'($urandom);
        bus.WriteData_IN     = $urandom;
        #1;
        checks++; if (bus.alloc_ready_OUT !== (m_q.size() < 64) || bus.alloc_entry_OUT !== 6'(m_tail)) begin
          errors++; $display("FAIL rand_alloc got ready=%b tag=%0d want %b %0d", bus.alloc_ready_OUT, bus.alloc_entry_OUT,
                             (m_q.size() < 64), m_tail);
        end
        cyc();
        checks++;
        if (bus.Commit_Valid_OUT !== e_cv || bus.Commit_RegWrite_OUT !== e_crw || bus.Commit_WriteRegister_OUT !== e_creg ||
            bus.Commit_WriteData_OUT !== e_cdata || bus.Commit_PC_OUT !== e_cpc || bus.Count_OUT !== 7'(m_q.size())) begin
          errors++;
          $display("FAIL rand_commit got v=%b rw=%b r%0d d=%h pc=%h cnt=%0d want v=%b rw=%b r%0d d=%h pc=%h cnt=%0d",
                   bus.Commit_Valid_OUT, bus.Commit_RegWrite_OUT, bus.Commit_WriteRegister_OUT, bus.Commit_WriteData_OUT,
                   bus.Commit_PC_OUT, bus.Count_OUT, e_cv, e_crw, e_creg, e_cdata, e_cpc, m_q.size());
        end
      end
    end
    idle();
  endtask

  initial begin
    RESET = 1;
    idle();
    m_reset();
    #3;
    test_reset();
    test_ordering();
    test_full_wrap();
    test_steady();
    test_stray();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
